// File: rtl/ctrl_pkg.sv
// Shared definitions for the sequencer control unit: step encoding, opcodes,
// ALU codes and bus-select offsets above the register range.
package ctrl_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVT  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_LD   = 3'd4;
  localparam logic [2:0] OP_ST   = 3'd5;
  localparam logic [2:0] OP_AND  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  // Non-register bus sources sit directly above the register codes: NREG + offset.
  localparam int SEL_G_OFS   = 0;
  localparam int SEL_D_OFS   = 1;
  localparam int SEL_DT_OFS  = 2;
  localparam int SEL_DIN_OFS = 3;

  function automatic logic [1:0] alu_code(input logic [2:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/reg_enable_decoder.sv
// Register write-enable decoder: turns a register index into a one-hot
// enable vector, all zero when the write enable is low.
module reg_enable_decoder #(
  parameter int NREG = 8,
  parameter int RW   = $clog2(NREG)
) (
  input  logic [RW-1:0]   addr,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-step instruction sequencer for a simple bus-based processor: steps
// T0..T3 and decodes IR into bus-select, register-write and ALU controls.
module seq_control_unit
  import ctrl_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [DW-1:0]            IR,
  input  logic                     mem_ready,
  output logic [$clog2(NREG)+1:0]  select,
  output logic [NREG-1:0]          Rin,
  output logic                     IRin,
  output logic                     Ain,
  output logic                     Gin,
  output logic                     ADDRin,
  output logic                     DOUTin,
  output logic                     W_D,
  output logic                     Done,
  output logic [1:0]               alu_op
);

  localparam int RW = $clog2(NREG);
  localparam int SW = RW + 2;

  localparam logic [SW-1:0] SEL_G   = SW'(NREG + SEL_G_OFS);
  localparam logic [SW-1:0] SEL_D   = SW'(NREG + SEL_D_OFS);
  localparam logic [SW-1:0] SEL_DT  = SW'(NREG + SEL_DT_OFS);
  localparam logic [SW-1:0] SEL_DIN = SW'(NREG + SEL_DIN_OFS);

  logic [2:0]    opcode;
  logic          imm;
  logic [RW-1:0] rx;
  logic [RW-1:0] ry;
  logic          unused_ir;

  assign opcode    = IR[DW-2:DW-4];
  assign imm       = IR[DW-5];
  assign rx        = IR[DW-6 -: RW];
  assign ry        = IR[RW-1:0];
  assign unused_ir = ^{IR[DW-1], IR[DW-6-RW:RW]};

  logic          is_alu;
  logic          is_short;
  logic [SW-1:0] sel_operand;

  assign is_alu      = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);
  assign is_short    = (opcode == OP_MV) || (opcode == OP_MVT) || (opcode == OP_RSVD);
  assign sel_operand = imm ? SEL_D : SW'(ry);

  state_t state;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of the order the statements appear in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= T0;
    end else begin
      unique case (state)
        T0: if (run) state <= T1;
        T1: state <= is_short ? T0 : T2;
        T2: begin
          if (is_alu)                state <= T3;
          else if (opcode == OP_LD)  state <= mem_ready ? T3 : T2;
          else                       state <= T0;
        end
        T3: state <= T0;
      endcase
    end
  end

  logic wr_en;

  // NOTE: every combinational output gets a default before the case, so steps that
  // do not mention a strobe leave it at 0 and no latch can be inferred.
  always_comb begin
    select = '0;
    wr_en  = 1'b0;
    IRin   = 1'b0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    ADDRin = 1'b0;
    DOUTin = 1'b0;
    W_D    = 1'b0;
    Done   = 1'b0;
    alu_op = ALU_ADD;
    unique case (state)
      T0: IRin = run;
      T1: begin
        case (opcode)
          OP_MV:  begin select = sel_operand; wr_en = 1'b1; Done = 1'b1; end
          OP_MVT: begin select = SEL_DT;      wr_en = 1'b1; Done = 1'b1; end
          OP_ADD, OP_SUB, OP_AND: begin select = SW'(rx); Ain = 1'b1; end
          OP_LD, OP_ST:           begin select = SW'(ry); ADDRin = 1'b1; end
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        if (is_alu) begin
          select = sel_operand;
          Gin    = 1'b1;
          alu_op = alu_code(opcode);
        end else if (opcode == OP_ST) begin
          select = SW'(rx);
          DOUTin = 1'b1;
          W_D    = 1'b1;
          Done   = 1'b1;
        end
      end
      T3: begin
        // Load waits in T2 with no strobes; it only reaches here once data is valid.
        if (is_alu) begin
          select = SEL_G;
          wr_en  = 1'b1;
          Done   = 1'b1;
        end else if (opcode == OP_LD) begin
          select = SEL_DIN;
          wr_en  = 1'b1;
          Done   = 1'b1;
        end
      end
    endcase
  end

  reg_enable_decoder #(
    .NREG (NREG),
    .RW   (RW)
  ) u_rin_dec (
    .addr   (rx),
    .en     (wr_en),
    .onehot (Rin)
  );

endmodule

// File: tb/tb_seq_control_unit.sv
// Self-checking bench for seq_control_unit (DW=16, NREG=8): directed
// instruction traces plus randomized instructions against a step-list model.
module tb_seq_control_unit;

  localparam int DW = 16;
  localparam int NREG = 8;
  localparam logic [4:0] G = 5'd8, D = 5'd9, DT = 5'd10, DIN = 5'd11;

  // strobe bit positions: {IRin, Ain, Gin, ADDRin, DOUTin, W_D, Done}
  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_IRIN = 7'b1000000;
  localparam logic [6:0] S_AIN  = 7'b0100000;
  localparam logic [6:0] S_GIN  = 7'b0010000;
  localparam logic [6:0] S_ADDR = 7'b0001000;
  localparam logic [6:0] S_DOUT = 7'b0000100;
  localparam logic [6:0] S_WD   = 7'b0000010;
  localparam logic [6:0] S_DONE = 7'b0000001;

  typedef struct packed {
    logic [4:0] sel;
    logic [7:0] rin;
    logic [6:0] strobes;
    logic [1:0] alu;
  } outs_t;

  logic          clk;
  logic          rst;
  logic          run;
  logic [DW-1:0] IR;
  logic          mem_ready;
  logic [4:0]    select;
  logic [7:0]    Rin;
  logic          IRin, Ain, Gin, ADDRin, DOUTin, W_D, Done;
  logic [1:0]    alu_op;

  int checks = 0;
  int failures = 0;
  outs_t exp_q[$];
  outs_t obs_q[$];

  seq_control_unit #(.DW(DW), .NREG(NREG)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .IR        (IR),
    .mem_ready (mem_ready),
    .select    (select),
    .Rin       (Rin),
    .IRin      (IRin),
    .Ain       (Ain),
    .Gin       (Gin),
    .ADDRin    (ADDRin),
    .DOUTin    (DOUTin),
    .W_D       (W_D),
    .Done      (Done),
    .alu_op    (alu_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic outs_t mk(input logic [4:0] sel, input logic [7:0] rin,
                               input logic [6:0] strobes, input logic [1:0] alu);
    outs_t o;
    o.sel = sel; o.rin = rin; o.strobes = strobes; o.alu = alu;
    return o;
  endfunction

  function automatic outs_t sample();
    return mk(select, Rin, {IRin, Ain, Gin, ADDRin, DOUTin, W_D, Done}, alu_op);
  endfunction

  // Step-list model: each instruction is a sequence of bus/strobe steps,
  // framed by the T0 fetch step before and after (run held high there).
  task automatic build_model(input logic [15:0] ir, input int w);
    logic [2:0] op = ir[14:12];
    logic       imm = ir[11];
    int         rx = int'(ir[10:8]);
    int         ry = int'(ir[2:0]);
    logic [4:0] src = imm ? D : 5'(ry);
    logic [7:0] onehot = 8'(1 << rx);
    exp_q.delete();
    exp_q.push_back(mk(5'd0, 8'h00, S_IRIN, 2'b00));
    case (op)
      3'd0: exp_q.push_back(mk(src, onehot, S_DONE, 2'b00));
      3'd1: exp_q.push_back(mk(DT, onehot, S_DONE, 2'b00));
      3'd2, 3'd3, 3'd6: begin
        exp_q.push_back(mk(5'(rx), 8'h00, S_AIN, 2'b00));
        exp_q.push_back(mk(src, 8'h00, S_GIN, (op == 3'd2) ? 2'b00 : (op == 3'd3) ? 2'b01 : 2'b10));
        exp_q.push_back(mk(G, onehot, S_DONE, 2'b00));
      end
      3'd4: begin
        exp_q.push_back(mk(5'(ry), 8'h00, S_ADDR, 2'b00));
        for (int i = 0; i <= w; i++) exp_q.push_back(mk(5'd0, 8'h00, S_NONE, 2'b00));
        exp_q.push_back(mk(DIN, onehot, S_DONE, 2'b00));
      end
      3'd5: begin
        exp_q.push_back(mk(5'(ry), 8'h00, S_ADDR, 2'b00));
        exp_q.push_back(mk(5'(rx), 8'h00, S_DOUT | S_WD | S_DONE, 2'b00));
      end
      default: exp_q.push_back(mk(5'd0, 8'h00, S_DONE, 2'b00));
    endcase
    exp_q.push_back(mk(5'd0, 8'h00, S_IRIN, 2'b00));
  endtask

  // Drives one instruction for exp_q.size() cycles and records the outputs.
  // For ld, mem_ready is low for the first w cycles of the wait step, then high.
  task automatic do_instr(input logic [15:0] ir, input int w);
    int n = exp_q.size() - 2;
    bit is_ld = (ir[14:12] == 3'd4);
    obs_q.delete();
    @(negedge clk);
    IR = ir; run = 1'b1; mem_ready = 1'($urandom);
    #1 obs_q.push_back(sample());
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      run = 1'($urandom);
      if (is_ld && k >= 1 && k <= w)  mem_ready = 1'b0;
      else if (is_ld && k == w + 1)   mem_ready = 1'b1;
      else                            mem_ready = 1'($urandom);
      #1 obs_q.push_back(sample());
    end
    @(negedge clk);
    run = 1'b1; mem_ready = 1'($urandom);
    #1 obs_q.push_back(sample());
    #1 run = 1'b0;
  endtask

  task automatic test_reset();
    outs_t got;
    rst = 1'b1; run = 1'b0; IR = '0; mem_ready = 1'b0;
    #2 got = sample();
    checks++;
    if (got !== mk(5'd0, 8'h00, S_NONE, 2'b00)) begin
      failures++; $display("FAIL reset_idle got=%h exp=%h", got, mk(5'd0, 8'h00, S_NONE, 2'b00));
    end
    run = 1'b1; IR = 16'h2205;
    #1 got = sample();
    checks++;
    if (got !== mk(5'd0, 8'h00, S_IRIN, 2'b00)) begin
      failures++; $display("FAIL reset_irin got=%h exp=%h", got, mk(5'd0, 8'h00, S_IRIN, 2'b00));
    end
    repeat (2) @(posedge clk);
    #1 got = sample();
    checks++;
    if (got !== mk(5'd0, 8'h00, S_IRIN, 2'b00)) begin
      failures++; $display("FAIL reset_holds_t0 got=%h exp=%h", got, mk(5'd0, 8'h00, S_IRIN, 2'b00));
    end
    @(negedge clk);
    run = 1'b0; rst = 1'b0;
    @(posedge clk);
    #1 got = sample();
    checks++;
    if (got !== mk(5'd0, 8'h00, S_NONE, 2'b00)) begin
      failures++; $display("FAIL t0_idle got=%h exp=%h", got, mk(5'd0, 8'h00, S_NONE, 2'b00));
    end
  endtask

  task automatic test_mv();
    exp_q.delete();
    exp_q.push_back(mk(5'd0, 8'h00, S_IRIN, 2'b00));
    exp_q.push_back(mk(5'd9, 8'h02, S_DONE, 2'b00));
    exp_q.push_back(mk(5'd0, 8'h00, S_IRIN, 2'b00));
    do_instr(16'h0955, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL mv step%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_add();
    exp_q.delete();
    exp_q.push_back(mk(5'd0, 8'h00, S_IRIN, 2'b00));
    exp_q.push_back(mk(5'd2, 8'h00, S_AIN, 2'b00));
    exp_q.push_back(mk(5'd5, 8'h00, S_GIN, 2'b00));
    exp_q.push_back(mk(5'd8, 8'h04, S_DONE, 2'b00));
    exp_q.push_back(mk(5'd0, 8'h00, S_IRIN, 2'b00));
    do_instr(16'h2205, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL add step%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ld_wait();
    exp_q.delete();
    exp_q.push_back(mk(5'd0, 8'h00, S_IRIN, 2'b00));
    exp_q.push_back(mk(5'd4, 8'h00, S_ADDR, 2'b00));
    repeat (4) exp_q.push_back(mk(5'd0, 8'h00, S_NONE, 2'b00));
    exp_q.push_back(mk(5'd11, 8'h08, S_DONE, 2'b00));
    exp_q.push_back(mk(5'd0, 8'h00, S_IRIN, 2'b00));
    do_instr(16'h4304, 3);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL ld_wait step%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ld_fast();
    exp_q.delete();
    exp_q.push_back(mk(5'd0, 8'h00, S_IRIN, 2'b00));
    exp_q.push_back(mk(5'd4, 8'h00, S_ADDR, 2'b00));
    exp_q.push_back(mk(5'd0, 8'h00, S_NONE, 2'b00));
    exp_q.push_back(mk(5'd11, 8'h08, S_DONE, 2'b00));
    exp_q.push_back(mk(5'd0, 8'h00, S_IRIN, 2'b00));
    do_instr(16'h4304, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL ld_fast step%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_st();
    exp_q.delete();
    exp_q.push_back(mk(5'd0, 8'h00, S_IRIN, 2'b00));
    exp_q.push_back(mk(5'd7, 8'h00, S_ADDR, 2'b00));
    exp_q.push_back(mk(5'd6, 8'h00, S_DOUT | S_WD | S_DONE, 2'b00));
    exp_q.push_back(mk(5'd0, 8'h00, S_IRIN, 2'b00));
    do_instr(16'h5607, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL st step%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reserved();
    exp_q.delete();
    exp_q.push_back(mk(5'd0, 8'h00, S_IRIN, 2'b00));
    exp_q.push_back(mk(5'd0, 8'h00, S_DONE, 2'b00));
    exp_q.push_back(mk(5'd0, 8'h00, S_IRIN, 2'b00));
    do_instr(16'h7000, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL reserved step%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    outs_t got;
    @(negedge clk);
    IR = 16'h3213; run = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    #1 got = sample();
    checks++;
    if (got !== mk(5'd3, 8'h00, S_GIN, 2'b01)) begin
      failures++; $display("FAIL sub_t2 got=%h exp=%h", got, mk(5'd3, 8'h00, S_GIN, 2'b01));
    end
    rst = 1'b1;
    #1 got = sample();
    checks++;
    if (got !== mk(5'd0, 8'h00, S_NONE, 2'b00)) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", got, mk(5'd0, 8'h00, S_NONE, 2'b00));
    end
    run = 1'b1;
    #1 got = sample();
    checks++;
    if (got !== mk(5'd0, 8'h00, S_IRIN, 2'b00)) begin
      failures++; $display("FAIL async_reset_t0 got=%h exp=%h", got, mk(5'd0, 8'h00, S_IRIN, 2'b00));
    end
    run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) rst = 1'b0;
      #1 got = sample();
      checks++;
      if (got !== mk(5'd0, 8'h00, S_NONE, 2'b00)) begin
        failures++; $display("FAIL aborted_quiet cyc%0d got=%h exp=%h", i, got, mk(5'd0, 8'h00, S_NONE, 2'b00));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [15:0] ir = 16'($urandom);
      int w = int'($urandom_range(0, 4));
      build_model(ir, w);
      do_instr(ir, w);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand ir=%h w=%0d step%0d got=%h exp=%h", ir, w, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mv();
    test_add();
    test_ld_wait();
    test_ld_fast();
    test_st();
    test_reserved();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
